// File: rtl/sobel_pkg.sv
// Shared types, constants and helpers for the Sobel magnitude stage.
// Build option: SOBEL_MAG_APPROX_EN (see sobel_magnitude.sv).
package sobel_pkg;

    // Default pixel width. grad_t follows it.
    localparam int unsigned WIDTH_C  = 8;

    // Columns/rows below this index lack a full 3x3 window.
    localparam int unsigned BORDER_C = 2;

    typedef logic signed [2*WIDTH_C-1:0] grad_t;

    // Clamp an unsigned sum to the largest value that fits in 'width' bits.
    function automatic logic [63:0] mag_sat(input logic [63:0] s, input int unsigned width);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        return (s > max_v) ? max_v : s;
    endfunction

endpackage

// File: rtl/sobel_raster_ctr.sv
// Raster column/row tracker for the Sobel magnitude stage.
// Advances on each accepted input pair and flags positions whose
// 3x3 window is not yet fully populated.
module sobel_raster_ctr
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH_P  = 16,
    parameter int unsigned HEIGHT_P = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic border_o
);

    localparam int unsigned CW = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
    localparam int unsigned RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Next-position logic: column wraps at end of row, row wraps at end of frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (en_i) begin
            if (col_q == CW'(DEPTH_P - 1)) begin
                col_d = '0;
                if (row_q == RW'(HEIGHT_P - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Border flag describes the pair being accepted at the current position.
    always_comb begin
        border_o = (32'(col_q) < BORDER_C) || (32'(row_q) < BORDER_C);
    end

endmodule

// File: rtl/sobel_magnitude.sv
// Sobel gradient magnitude stage: |gx|,|gy| -> saturated magnitude + edge flag.
// Two registered stages with valid/ready flow control; border pixels emit zero.
// Build option: define SOBEL_MAG_APPROX_EN to use max + min/2 instead of |gx|+|gy|.
module sobel_magnitude
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P  = 8,
    parameter int unsigned DEPTH_P  = 16,
    parameter int unsigned HEIGHT_P = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [2*WIDTH_P-1:0] gx_i,
    input  logic signed [2*WIDTH_P-1:0] gy_i,
    input  logic [WIDTH_P-1:0]          threshold_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [WIDTH_P-1:0]          mag_o,
    output logic                        edge_o
);

    localparam int unsigned GW = 2 * WIDTH_P;
    localparam int unsigned SW = GW + 1;

    logic              ld1, ld2, xfer, border;

    logic              v1_q, v1_d;
    logic [GW-1:0]     ax_q, ax_d;
    logic [GW-1:0]     ay_q, ay_d;
    logic              b1_q, b1_d;

    logic              v2_q, v2_d;
    logic [WIDTH_P-1:0] mag_q, mag_d;
    logic              edge_q, edge_d;

    logic [SW-1:0]     sum;
    logic [WIDTH_P-1:0] mag_c;
    logic              edge_c;

    sobel_raster_ctr #(
        .DEPTH_P  (DEPTH_P),
        .HEIGHT_P (HEIGHT_P)
    ) u_raster (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (xfer),
        .border_o (border)
    );

    // Flow control: a stage advances when it is empty or its successor advances.
    always_comb begin
        ld2     = ~v2_q | ready_i;
        ld1     = ~v1_q | ld2;
        ready_o = ld1;
        xfer    = valid_i & ld1;
    end

    // Stage 1: absolute values (most-negative input maps exactly to 2^(GW-1)).
    always_comb begin
        v1_d = v1_q;
        ax_d = ax_q;
        ay_d = ay_q;
        b1_d = b1_q;
        if (ld1) begin
            v1_d = valid_i;
            if (valid_i) begin
                ax_d = gx_i[GW-1] ? (~$unsigned(gx_i) + GW'(1)) : $unsigned(gx_i);
                ay_d = gy_i[GW-1] ? (~$unsigned(gy_i) + GW'(1)) : $unsigned(gy_i);
                b1_d = border;
            end
        end
    end

    // Stage 2 datapath: magnitude estimate, saturation, threshold, border masking.
    always_comb begin
`ifdef SOBEL_MAG_APPROX_EN
        logic [GW-1:0] mx;
        logic [GW-1:0] mn;
        mx  = (ax_q >= ay_q) ? ax_q : ay_q;
        mn  = (ax_q >= ay_q) ? ay_q : ax_q;
        sum = {1'b0, mx} + {2'b00, mn[GW-1:1]};
`else
        sum = {1'b0, ax_q} + {1'b0, ay_q};
`endif
        mag_c  = WIDTH_P'(mag_sat(64'(sum), WIDTH_P));
        edge_c = (mag_c >= threshold_i);
        if (b1_q) begin
            mag_c  = '0;
            edge_c = 1'b0;
        end
    end

    // Stage 2 register load; outputs hold while downstream stalls.
    always_comb begin
        v2_d   = v2_q;
        mag_d  = mag_q;
        edge_d = edge_q;
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
                mag_d  = mag_c;
                edge_d = edge_c;
            end
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1_q   <= 1'b0;
            ax_q   <= '0;
            ay_q   <= '0;
            b1_q   <= 1'b0;
            v2_q   <= 1'b0;
            mag_q  <= '0;
            edge_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            ax_q   <= ax_d;
            ay_q   <= ay_d;
            b1_q   <= b1_d;
            v2_q   <= v2_d;
            mag_q  <= mag_d;
            edge_q <= edge_d;
        end
    end

    assign valid_o = v2_q;
    assign mag_o   = mag_q;
    assign edge_o  = edge_q;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Self-checking bench for sobel_magnitude (WIDTH 8, 4x4 frame).
module tb_sobel_magnitude;
    import sobel_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
    localparam int unsigned H = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic        ready_o;
    grad_t       gx_i;
    grad_t       gy_i;
    logic [W-1:0] threshold_i;
    logic        valid_o;
    logic        ready_i;
    logic [W-1:0] mag_o;
    logic        edge_o;

    always #5 clk_i = ~clk_i;

    sobel_magnitude #(
        .WIDTH_P  (W),
        .DEPTH_P  (D),
        .HEIGHT_P (H)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .gx_i        (gx_i),
        .gy_i        (gy_i),
        .threshold_i (threshold_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .mag_o       (mag_o),
        .edge_o      (edge_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: result of one pair at raster index p.
    typedef struct {
        logic [W-1:0] mag;
        logic         edg;
    } res_t;

    function automatic res_t model(input int gx, input int gy, input int p, input int thr);
        res_t r;
        int   col, row, ax, ay, s, mx, mn;
        col = p % D;
        row = p / D;
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
`ifdef SOBEL_MAG_APPROX_EN
        mx  = (ax > ay) ? ax : ay;
        mn  = (ax > ay) ? ay : ax;
        s   = mx + mn / 2;
`else
        mx  = 0;
        mn  = 0;
        s   = ax + ay;
`endif
        if (s > 255) s = 255;
        if (col < 2 || row < 2) s = 0;
        r.mag = s[W-1:0];
        r.edg = (col >= 2 && row >= 2) && (s >= thr);
        return r;
    endfunction

    res_t         exp_q[$];
    res_t         e;
    int           pos = 0;
    int           n_in = 0;
    int           n_out = 0;
    logic         hold_prev = 1'b0;
    logic [W-1:0] mag_prev;
    logic         edge_prev;

    // Scoreboard: sample handshakes mid-cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            exp_q.delete();
            pos       = 0;
            n_in      = 0;
            n_out     = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_eq("hold_valid", valid_o, 1);
                check_eq("hold_mag", mag_o, mag_prev);
                check_eq("hold_edge", edge_o, edge_prev);
            end
            if (valid_o && ready_i) begin
                check_eq("scb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_mag", mag_o, e.mag);
                    check_eq("out_edge", edge_o, e.edg);
                end
                n_out++;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(model(int'(gx_i), int'(gy_i), pos, int'(threshold_i)));
                pos = (pos + 1) % (D * H);
                n_in++;
            end
            hold_prev = valid_o && !ready_i;
            mag_prev  = mag_o;
            edge_prev = edge_o;
        end
    end

    function automatic grad_t rand_grad();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 600)) - 300;
            1:       v = int'($urandom_range(0, 65535)) - 32768;
            2:       v = $urandom_range(0, 1) ? 32767 : -32768;
            default: v = $urandom_range(0, 1) ? int'($urandom_range(0, 200)) : -int'($urandom_range(0, 200));
        endcase
        return grad_t'(v);
    endfunction

    // Present one pair and wait (bounded) until it is accepted.
    task automatic send(input grad_t gx, input grad_t gy);
        logic ok;
        ok      = 1'b0;
        valid_i = 1'b1;
        gx_i    = gx;
        gy_i    = gy;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            ok = ready_o;
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        check_eq("send_accept", ok, 1);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic bp_ok;
        int   exp_small;

        rstn_i      = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        gx_i        = '0;
        gy_i        = '0;
        threshold_i = 8'd100;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_mag", mag_o, 0);
        check_eq("rst_edge", edge_o, 0);
        #2 rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("rst_ready", ready_o, 1);

        // Walk to (2,2), then the directed small pair with latency check
        for (int i = 0; i < 10; i++) send(rand_grad(), rand_grad());
        idle(4);
        send(grad_t'(3), grad_t'(-4));
        check_eq("lat_c1_valid", valid_o, 0);
        @(posedge clk_i);
        #1;
`ifdef SOBEL_MAG_APPROX_EN
        exp_small = 5;
`else
        exp_small = 7;
`endif
        check_eq("lat_c2_valid", valid_o, 1);
        check_eq("small_mag", mag_o, exp_small);
        check_eq("small_edge", edge_o, 0);
        idle(3);

        // (3,2): most-negative gradients saturate
        send(grad_t'(-32768), grad_t'(-32768));
        @(posedge clk_i);
        #1;
        check_eq("sat_valid", valid_o, 1);
        check_eq("sat_mag", mag_o, 255);
        check_eq("sat_edge", edge_o, 1);
        idle(3);

        // Finish frame, then two full frames of gx=200
        for (int i = 0; i < 4; i++) send(rand_grad(), rand_grad());
        for (int i = 0; i < 32; i++) send(grad_t'(200), grad_t'(0));
        idle(4);

        // Backpressure: two pairs fill the pipe, third waits
        ready_i = 1'b0;
        valid_i = 1'b1;
        gx_i    = grad_t'(11);
        gy_i    = grad_t'(-5);
        @(negedge clk_i);
        check_eq("bp_ready_a", ready_o, 1);
        @(posedge clk_i);
        #1;
        gx_i = grad_t'(-40);
        gy_i = grad_t'(90);
        @(negedge clk_i);
        check_eq("bp_ready_b", ready_o, 1);
        @(posedge clk_i);
        #1;
        gx_i = grad_t'(120);
        gy_i = grad_t'(7);
        @(negedge clk_i);
        check_eq("bp_ready_full", ready_o, 0);
        repeat (3) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        bp_ok   = 1'b0;
        for (int i = 0; i < 20 && !bp_ok; i++) begin
            @(negedge clk_i);
            bp_ok = ready_o;
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        check_eq("bp_third_accept", bp_ok, 1);
        idle(5);

        // Realign to frame start, then reset mid-stream with a live output
        for (int i = 0; i < 13; i++) send(rand_grad(), rand_grad());
        idle(4);
        for (int i = 0; i < 11; i++) send(grad_t'(200), grad_t'(0));
        @(posedge clk_i);
        #2;
        check_eq("pre_rst_valid", valid_o, 1);
        check_eq("pre_rst_mag", mag_o, 200);
        rstn_i = 1'b0;
        #1;
        check_eq("async_rst_valid", valid_o, 0);
        check_eq("async_rst_mag", mag_o, 0);
        check_eq("async_rst_edge", edge_o, 0);
        repeat (2) @(posedge clk_i);
        #3 rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("post_rst_ready", ready_o, 1);
        check_eq("post_rst_valid", valid_o, 0);

        // Random valid/ready traffic
        threshold_i = 8'($urandom_range(0, 255));
        for (int cyc = 0; cyc < 20000 && n_in < 1000; cyc++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 9) < 7);
            gx_i    = rand_grad();
            gy_i    = rand_grad();
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk_i);
            #1;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        check_eq("rand_in_count", n_in >= 1000, 1);
        check_eq("io_count", n_out, n_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
